// File: rtl/screen_scanner.sv
// Screen memory read-side scanner: fetches one 16-pixel word per address and
// streams its pixels LSB first over a valid/ready handshake, flagging row and frame ends.
module screen_scanner #(
  parameter int WORDS_PER_ROW = 32,
  parameter int ROWS          = 256,
  parameter int ADDR_W        = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] address,
  input  logic [15:0]       data,
  output logic              pixel,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              row_end,
  output logic              frame_end
);

  localparam int COL_W = $clog2(WORDS_PER_ROW);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_ROW * ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [15:0]       shift_q, shift_d;
  logic [3:0]        count_q, count_d;

  logic last_bit;
  logic transfer;

  assign last_bit = (count_q == 4'd15);
  assign transfer = pixel_valid && pixel_ready;

  // NOTE: every signal assigned in this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    shift_d   = shift_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = FETCH;
      end
      FETCH: begin
        shift_d = data;
        count_d = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (transfer) begin
          shift_d = {1'b0, shift_q[15:1]};
          count_d = count_q + 4'd1;
          if (last_bit) begin
            address_d = address_q + ADDR_W'(1);
            state_d   = enable ? FETCH : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      address_q <= '0;
      shift_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
    end
  end

  // Markers look at the word currently being shown, so they sit in front of the address increment.
  assign address     = address_q;
  assign pixel_valid = (state_q == SHIFT);
  assign pixel       = pixel_valid && shift_q[0];
  assign row_end     = pixel_valid && last_bit && (address_q[COL_W-1:0] == {COL_W{1'b1}});
  assign frame_end   = pixel_valid && last_bit && (address_q == LAST_ADDR);

endmodule

// File: tb/tb_screen_scanner.sv
// Self-checking bench for screen_scanner: table-driven word vectors, a pixel-stream
// reference model over a bench-owned memory, and directed multi-cycle corner cases.
module tb_screen_scanner;

  localparam int WPR         = 32;
  localparam int ROWS_T      = 16;
  localparam int AW          = 9;
  localparam int FRAME_WORDS = WPR * ROWS_T;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] address;
  logic [15:0]   data;
  logic          pixel;
  logic          pixel_valid;
  logic          pixel_ready;
  logic          row_end;
  logic          frame_end;

  logic [15:0] mem [FRAME_WORDS];

  screen_scanner #(
    .WORDS_PER_ROW(WPR),
    .ROWS         (ROWS_T),
    .ADDR_W       (AW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .address    (address),
    .data       (data),
    .pixel      (pixel),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .row_end    (row_end),
    .frame_end  (frame_end)
  );

  assign data = mem[address];

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the pixel stream is word exp_addr, bit exp_bit of mem, advanced per transfer.
  int exp_addr;
  int exp_bit;
  bit prev_hold;
  int tick;
  int fe_tick;
  int fe_count;
  int re_count;
  bit cap[$];

  typedef struct {
    logic [15:0] word;
    logic [15:0] order;   // order[15] is the first (leftmost) pixel
    int          stall_at;
    int          stall_len;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_addr  = 0;
    exp_bit   = 0;
    prev_hold = 1'b0;
  endtask

  task automatic check_cycle();
    bit last;
    if (prev_hold) check("hold_valid", pixel_valid, 1);
    check("address", address, exp_addr);
    if (pixel_valid) begin
      last = (exp_bit == 15);
      check("pixel", pixel, mem[exp_addr][exp_bit]);
      check("row_end", row_end, last && (exp_addr % WPR == WPR - 1));
      check("frame_end", frame_end, last && (exp_addr == FRAME_WORDS - 1));
    end else begin
      check("row_end_idle", row_end, 0);
      check("frame_end_idle", frame_end, 0);
    end
    prev_hold = pixel_valid && !pixel_ready;
  endtask

  task automatic scan(input int n, input int stall_at, input int stall_len, input bit rnd);
    int done = 0;
    int cyc = 0;
    int stall_left = 0;
    cap.delete();
    while (done < n) begin
      @(negedge clock);
      tick++;
      cyc++;
      if (cyc > n * 40 + 100) begin
        check("scan_timeout", done, n);
        return;
      end
      if (stall_left > 0) begin
        pixel_ready = 1'b0;
        stall_left--;
      end else begin
        pixel_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      check_cycle();
      if (pixel_valid && pixel_ready) begin
        cap.push_back(pixel);
        if (row_end) re_count++;
        if (frame_end) begin
          fe_count++;
          if (fe_count == 1) fe_tick = tick;
        end
        if (exp_bit == 15) begin
          exp_bit  = 0;
          exp_addr = (exp_addr + 1) % FRAME_WORDS;
        end else begin
          exp_bit++;
        end
        done++;
        if (done == stall_at) stall_left = stall_len;
      end
    end
  endtask

  initial begin
    logic [15:0] got;

    tbl[0] = '{16'h0001, 16'b1000_0000_0000_0000, 0, 0};
    tbl[1] = '{16'hA5A5, 16'b1010_0101_1010_0101, 3, 5};
    tbl[2] = '{16'h8000, 16'b0000_0000_0000_0001, 0, 0};
    tbl[3] = '{16'h00FF, 16'b1111_1111_0000_0000, 8, 3};
    tbl[4] = '{16'h1234, 16'b0010_1100_0100_1000, 15, 2};

    for (int i = 0; i < FRAME_WORDS; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) mem[i] = tbl[i].word;
    mem[31] = 16'h8000;

    reset       = 1'b1;
    enable      = 1'b0;
    pixel_ready = 1'b0;
    tick        = 0;
    fe_count    = 0;
    re_count    = 0;
    fe_tick     = -1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_address", address, 0);
    check("rst_pixel", pixel, 0);
    check("rst_valid", pixel_valid, 0);
    check("rst_row_end", row_end, 0);
    check("rst_frame_end", frame_end, 0);

    // Basic fetch latency: FETCH bubble, then valid two edges after enable
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clock);
    check("fetch_valid", pixel_valid, 0);
    check("fetch_address", address, 0);
    @(negedge clock);
    check("valid_rise", pixel_valid, 1);
    check_cycle();

    // Table-driven words 0..4, with backpressure on some of them
    for (int i = 0; i < 5; i++) begin
      scan(16, tbl[i].stall_at, tbl[i].stall_len, 1'b0);
      got = '0;
      for (int k = 0; k < 16 && k < cap.size(); k++) got[15-k] = cap[k];
      check("table_word", got, tbl[i].order);
      @(negedge clock);
      check("fetch_bubble", pixel_valid, 0);
      check("next_addr", address, i + 1);
    end

    // Row end on word 31 under random backpressure
    re_count = 0;
    scan(16 * 27, 0, 0, 1'b1);
    check("row_end_count", re_count, 1);
    check("row_end_pixel", cap[cap.size()-1], 1);
    @(negedge clock);
    check("row_next_addr", address, 32);

    // Reset during SHIFT of word 100 at bit 9
    scan(16 * 68 + 9, 0, 0, 1'b1);
    @(negedge clock);
    pixel_ready = 1'b0;
    check("pre_reset_addr", address, 100);
    check_cycle();
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_address", address, 0);
    check("mid_rst_valid", pixel_valid, 0);
    check("mid_rst_row_end", row_end, 0);
    check("mid_rst_frame_end", frame_end, 0);
    model_reset();
    reset = 1'b0;

    // Restart from mem[0] bit 0, then drop enable after 7th transfer of word 5
    scan(16 * 5 + 7, 0, 0, 1'b1);
    check("restart_bit0", cap[0], mem[0][0]);
    enable = 1'b0;
    scan(9, 0, 0, 1'b1);
    repeat (3) begin
      @(negedge clock);
      check("idle_valid", pixel_valid, 0);
      check("idle_address", address, 6);
    end
    enable = 1'b1;
    scan(16, 0, 0, 1'b1);
    got = '0;
    for (int k = 0; k < 16 && k < cap.size(); k++) got[k] = cap[k];
    check("resume_word6", got, mem[6]);

    // Full frame with ready tied high: frame_end timing and address wrap
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    model_reset();
    fe_count    = 0;
    re_count    = 0;
    reset       = 1'b0;
    enable      = 1'b1;
    pixel_ready = 1'b1;
    @(negedge clock);
    check("frame_fetch_valid", pixel_valid, 0);
    tick = 0;
    scan(FRAME_WORDS * 16, 0, 0, 1'b0);
    check("frame_end_count", fe_count, 1);
    check("frame_end_tick", fe_tick, FRAME_WORDS * 17 - 1);
    check("frame_row_ends", re_count, ROWS_T);
    scan(16, 0, 0, 1'b0);
    check("wrap_first_pixel", cap[0], mem[0][0]);
    check("frame_end_once", fe_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/screen_scanner.md
Name: screen_scanner

Overview:
- Read-side initiator for the 8K-word screen memory (512x256 monochrome, 32 words per row, 16 pixels per word).
- Drives a word address into the memory and captures the combinationally-read data word.
- Serialises the word into a pixel stream under a valid/ready handshake toward the display/output sink.
- Generates row-end and frame-end markers; sits between screen RAM and the video output logic.

Parameters:
WORDS_PER_ROW, 32, words per scan row; must be a power of two
ROWS, 256, scan rows per frame
ADDR_W, 13, memory address width; WORDS_PER_ROW*ROWS == 2**ADDR_W

Ports:
clock  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
enable  input  1  scan permitted; sampled at word boundaries only
address  output  ADDR_W  word address to screen memory (registered)
data  input  16  memory read data for current address (combinational read)
pixel  output  1  current pixel value (1 = black)
pixel_valid  output  1  pixel holds a valid pixel
pixel_ready  input  1  sink accepts pixel this cycle
row_end  output  1  current pixel is the last pixel of a row
frame_end  output  1  current pixel is the last pixel of the frame

Behaviour:
- One clock and one reset: clock is `clock`; reset is `reset`, synchronous and active-high.
- Reset values:
  - state IDLE, address 0, shift register 0, bit counter 0.
  - pixel 0, pixel_valid 0, row_end 0, frame_end 0.
- States:
  - IDLE: pixel_valid=0. If enable=1 at an edge, go to FETCH; address is unchanged.
  - FETCH: exactly one cycle; address is stable for the whole cycle. At the edge, load data into the shift register, clear the bit counter and go to SHIFT.
  - SHIFT: pixel_valid=1 and pixel=shift_reg[0]. Pixel order is LSB first, so bit 0 is the leftmost pixel of the word.
- Handshake:
  - A transfer occurs on an edge where pixel_valid&&pixel_ready.
  - Each transfer shifts the register right by 1 and increments the bit counter.
  - With pixel_valid=1 and pixel_ready=0, pixel, pixel_valid, row_end and frame_end hold unchanged.
  - pixel_valid never drops without a transfer, except on reset.
- Word boundary is a transfer while bit counter==15. On that edge:
  - address increments modulo 2**ADDR_W, so 8191 wraps to 0.
  - Next state is FETCH if enable=1, else IDLE.
- Enable deasserted mid-word:
  - The current word completes, all 16 pixels are delivered, then the block goes to IDLE.
  - The address points at the next word; re-enable resumes from there.
- Markers:
  - Both are combinational from state, counter and address, and are qualified by pixel_valid.
  - row_end = SHIFT && counter==15 && address[log2(WORDS_PER_ROW)-1:0]==all-ones.
  - frame_end = SHIFT && counter==15 && address==2**ADDR_W-1. frame_end implies row_end.
- Throughput: 16 pixels per 17 cycles with pixel_ready tied high (one FETCH bubble per word).
- Reset during any state: the next cycle is the reset state and the partial word is discarded.
- The block never writes memory; it has no load output.

Test Plan:
- Basic fetch: reset 2 cycles, mem[0]=16'h0001, pixel_ready=1, enable=1 -> address=0 throughout; pixel_valid rises 2 cycles after enable; pixels 1,0,0,...,0 (16 total); address=1 after the 16th transfer; pixel_valid low for the single FETCH cycle.
- Backpressure: mem[0]=16'hA5A5, drop pixel_ready for 5 cycles after the 3rd transfer -> pixel holds 0 (bit 3), pixel_valid stays 1, counter frozen; stream resumes 0,1,0,1,1,0,1,0,... with no pixel lost or duplicated.
- Row end: mem[31]=16'h8000, scan from address 0 -> row_end=1 only while the 16th pixel of word 31 is presented, with pixel=1; row_end=0 elsewhere; address=32 afterwards.
- Frame wrap: scan a full frame with ready=1 -> frame_end high exactly once, at cycle 8192*17 - 1 relative to the first FETCH, coincident with row_end; address wraps 8191->0; the next frame's first pixel equals mem[0] bit 0.
- Enable drop: deassert enable after the 7th transfer of word 5 -> remaining 9 pixels delivered, then IDLE with address=6 and pixel_valid=0; re-enable -> FETCH of address 6 and mem[6] pixels follow.
- Reset mid-operation: assert reset during SHIFT of word 100 at bit 9 -> next cycle address=0, pixel_valid=0, row_end=0, frame_end=0; after release with enable=1, scanning restarts at mem[0] bit 0.
